// File: rtl/ahb_lite_master_if.sv
// Command-side and AHB-Lite bus signals of ahb_lite_master, grouped as one bundle.
// The master modport is the initiator; the slave modport is the command source plus AHB target.
interface ahb_lite_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_W-1:0]     cmd_addr;
    logic                  cmd_write;
    logic [2:0]            cmd_size;
    logic                  cmd_burst;
    logic [4*DATA_W-1:0]   cmd_wdata;
    logic                  rd_valid;
    logic [DATA_W-1:0]     rd_data;
    logic                  done;
    logic                  err;

    logic [ADDR_W-1:0]     haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic [DATA_W-1:0]     hwdata;
    logic [DATA_W-1:0]     hrdata;
    logic                  hready;
    logic [1:0]            hresp;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_burst, cmd_wdata,
        input  hrdata, hready, hresp,
        output cmd_ready, rd_valid, rd_data, done, err,
        output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_burst, cmd_wdata,
        output hrdata, hready, hresp,
        input  cmd_ready, rd_valid, rd_data, done, err,
        input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
    );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: converts a command handshake into SINGLE/INCR4 pipelined transfers.
// Define AHB_MST_RETRY_EN to re-issue beats after RETRY/SPLIT (otherwise treated as ERROR).
module ahb_lite_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input logic               clk,
    input logic               rst,
    ahb_lite_master_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PIPE, S_LAST, S_ERR1} state_e;

    localparam logic [1:0] TR_IDLE      = 2'b00;
    localparam logic [1:0] TR_NONSEQ    = 2'b10;
    localparam logic [1:0] TR_SEQ       = 2'b11;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR4  = 3'b011;

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        haddr_q, haddr_d;
    logic [1:0]               htrans_q, htrans_d;
    logic                     hwrite_q, hwrite_d;
    logic [2:0]               hsize_q, hsize_d;
    logic [2:0]               hburst_q, hburst_d;
    logic [DATA_W-1:0]        hwdata_q, hwdata_d;
    logic [3:0][DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]               addr_beat_q, addr_beat_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]        rd_data_q, rd_data_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic [ADDR_W-1:0]        addr_inc;
    logic                     more_beats;
    logic                     size_ok, align_ok, bound_ok, cmd_ok;
    logic [10:0]              burst_end;

`ifdef AHB_MST_RETRY_EN
    logic                     retry_q, retry_d;
    logic [3:0]               retry_cnt_q, retry_cnt_d;
    logic [1:0]               data_beat_q, data_beat_d;
    logic [ADDR_W-1:0]        data_addr_q, data_addr_d;
`endif

    // Command legality: size, natural alignment, and INCR4 staying inside one 1KB page
    always_comb begin
        size_ok   = (bus.cmd_size <= 3'b010);
        burst_end = {1'b0, bus.cmd_addr[9:0]} + (11'd4 << bus.cmd_size[1:0]);
        bound_ok  = !bus.cmd_burst || (burst_end <= 11'd1024);
        case (bus.cmd_size)
            3'b001:  align_ok = !bus.cmd_addr[0];
            3'b010:  align_ok = (bus.cmd_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        cmd_ok = size_ok && align_ok && bound_ok;
    end

    assign addr_inc   = ADDR_W'(1) << hsize_q;
    assign more_beats = (hburst_q == BURST_INCR4) && (addr_beat_q != 2'd3);

    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hburst_d    = hburst_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        addr_beat_d = addr_beat_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        done_d      = 1'b0;
        err_d       = err_q;
`ifdef AHB_MST_RETRY_EN
        retry_d     = retry_q;
        retry_cnt_d = retry_cnt_q;
        data_beat_d = data_beat_q;
        data_addr_d = data_addr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (cmd_ok) begin
                        state_d     = S_ADDR;
                        haddr_d     = bus.cmd_addr;
                        htrans_d    = TR_NONSEQ;
                        hwrite_d    = bus.cmd_write;
                        hsize_d     = bus.cmd_size;
                        hburst_d    = bus.cmd_burst ? BURST_INCR4 : BURST_SINGLE;
                        wdata_d     = bus.cmd_wdata;
                        addr_beat_d = '0;
`ifdef AHB_MST_RETRY_EN
                        retry_cnt_d = '0;
`endif
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end

            S_ADDR, S_PIPE, S_LAST: begin
                if (state_q != S_ADDR && bus.hresp != RESP_OKAY) begin
                    htrans_d = TR_IDLE;
                    if (bus.hready) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_ERR1;
`ifdef AHB_MST_RETRY_EN
                        retry_d = bus.hresp[1];
`endif
                    end
                end else if (bus.hready) begin
                    if (state_q != S_ADDR && !hwrite_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = bus.hrdata;
                    end
                    if (state_q == S_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b0;
                    end else begin
                        // Address of the current beat accepted: it enters its data phase
                        hwdata_d = wdata_q[addr_beat_q];
`ifdef AHB_MST_RETRY_EN
                        data_beat_d = addr_beat_q;
                        data_addr_d = haddr_q;
`endif
                        if (more_beats) begin
                            state_d     = S_PIPE;
                            haddr_d     = haddr_q + addr_inc;
                            htrans_d    = TR_SEQ;
                            addr_beat_d = addr_beat_q + 2'd1;
                        end else begin
                            state_d  = S_LAST;
                            htrans_d = TR_IDLE;
                        end
                    end
                end
            end

            S_ERR1: begin
                if (bus.hready) begin
`ifdef AHB_MST_RETRY_EN
                    // Restart from the failed beat; later beats follow as SEQ
                    if (retry_q && retry_cnt_q != 4'd15) begin
                        state_d     = S_ADDR;
                        haddr_d     = data_addr_q;
                        htrans_d    = TR_NONSEQ;
                        addr_beat_d = data_beat_q;
                        retry_cnt_d = retry_cnt_q + 4'd1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
`else
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
`endif
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            haddr_q     <= '0;
            htrans_q    <= TR_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hburst_q    <= '0;
            hwdata_q    <= '0;
            wdata_q     <= '0;
            addr_beat_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hburst_q    <= hburst_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            addr_beat_q <= addr_beat_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef AHB_MST_RETRY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_q     <= 1'b0;
            retry_cnt_q <= '0;
            data_beat_q <= '0;
            data_addr_q <= '0;
        end else begin
            retry_q     <= retry_d;
            retry_cnt_q <= retry_cnt_d;
            data_beat_q <= data_beat_d;
            data_addr_q <= data_addr_d;
        end
    end
`endif

    assign bus.cmd_ready = (state_q == S_IDLE) && !rst;
    // Cancel the pending SEQ already in the first cycle of a two-cycle error response
    assign bus.htrans    = (state_q == S_PIPE && bus.hresp != RESP_OKAY) ? TR_IDLE : htrans_q;
    assign bus.haddr     = haddr_q;
    assign bus.hwrite    = hwrite_q;
    assign bus.hsize     = hsize_q;
    assign bus.hburst    = hburst_q;
    assign bus.hprot     = 4'b0001;
    assign bus.hwdata    = hwdata_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: a vector table of single commands plus
// hand-written burst, wait-state, error, reset and retry sequences.
module tb_ahb_lite_master;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ahb_lite_master_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();
    ahb_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    localparam int NC = 16;
    logic        rdy_s   [NC];
    logic [1:0]  resp_s  [NC];
    logic [31:0] rdata_s [NC];
    logic        rst_s   [NC];

    logic [1:0]  tr_htrans [NC];
    logic [31:0] tr_haddr  [NC];
    logic [31:0] tr_hwdata [NC];
    logic [31:0] tr_rd     [NC];
    logic        tr_rv     [NC];
    logic        tr_done   [NC];
    logic        tr_err    [NC];
    logic        tr_ready  [NC];
    logic        tr_hwrite [NC];
    logic [2:0]  tr_hsize  [NC];
    logic [2:0]  tr_hburst [NC];

    typedef struct {
        string       nm;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        burst;
        logic [31:0] wd0;
        logic [31:0] rd0;
        logic        exp_err;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_scripts();
        for (int k = 0; k < NC; k++) begin
            rdy_s[k]   = 1'b1;
            resp_s[k]  = 2'b00;
            rdata_s[k] = '0;
            rst_s[k]   = 1'b0;
        end
    endtask

    // Called just after a posedge with the DUT idle; cycle k starts k-1 edges after acceptance
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic burst, input logic [127:0] wd, input int ncyc);
        bus_if.cmd_write = wr;
        bus_if.cmd_addr  = addr;
        bus_if.cmd_size  = size;
        bus_if.cmd_burst = burst;
        bus_if.cmd_wdata = wd;
        bus_if.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus_if.cmd_valid = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            rst           = rst_s[k];
            bus_if.hready = rdy_s[k];
            bus_if.hresp  = resp_s[k];
            bus_if.hrdata = rdata_s[k];
            @(negedge clk);
            tr_htrans[k] = bus_if.htrans;
            tr_haddr[k]  = bus_if.haddr;
            tr_hwdata[k] = bus_if.hwdata;
            tr_rd[k]     = bus_if.rd_data;
            tr_rv[k]     = bus_if.rd_valid;
            tr_done[k]   = bus_if.done;
            tr_err[k]    = bus_if.err;
            tr_ready[k]  = bus_if.cmd_ready;
            tr_hwrite[k] = bus_if.hwrite;
            tr_hsize[k]  = bus_if.hsize;
            tr_hburst[k] = bus_if.hburst;
            @(posedge clk);
            #1;
        end
        rst           = 1'b0;
        bus_if.hready = 1'b1;
        bus_if.hresp  = 2'b00;
        bus_if.hrdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        vecs[0] = '{"wr_single_100", 1'b1, 32'h100, 3'b010, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1] = '{"rd_single_104", 1'b0, 32'h104, 3'b010, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[2] = '{"wr_byte_101",   1'b1, 32'h101, 3'b000, 1'b0, 32'h000000A5, 32'h0,        1'b0};
        vecs[3] = '{"rd_half_102",   1'b0, 32'h102, 3'b001, 1'b0, 32'h0,        32'h0000BEEF, 1'b0};
        vecs[4] = '{"bad_size3",     1'b1, 32'h100, 3'b011, 1'b0, 32'h12345678, 32'h0,        1'b1};
        vecs[5] = '{"bad_align_102", 1'b0, 32'h102, 3'b010, 1'b0, 32'h0,        32'h0,        1'b1};
        vecs[6] = '{"bad_1k_3f8",    1'b0, 32'h3F8, 3'b010, 1'b1, 32'h0,        32'h0,        1'b1};
        vecs[7] = '{"bad_half_103",  1'b1, 32'h103, 3'b001, 1'b0, 32'h0,        32'h0,        1'b1};
        vecs[8] = '{"bad_size4",     1'b0, 32'h000, 3'b100, 1'b0, 32'h0,        32'h0,        1'b1};

        rst              = 1'b1;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_addr  = '0;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_size  = '0;
        bus_if.cmd_burst = 1'b0;
        bus_if.cmd_wdata = '0;
        bus_if.hready    = 1'b1;
        bus_if.hresp     = 2'b00;
        bus_if.hrdata    = '0;
        clear_scripts();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_htrans",   bus_if.htrans,    2'b00);
        chk("rst_haddr",    bus_if.haddr,     32'h0);
        chk("rst_hwrite",   bus_if.hwrite,    1'b0);
        chk("rst_hsize",    bus_if.hsize,     3'b000);
        chk("rst_hburst",   bus_if.hburst,    3'b000);
        chk("rst_hwdata",   bus_if.hwdata,    32'h0);
        chk("rst_rd_valid", bus_if.rd_valid,  1'b0);
        chk("rst_rd_data",  bus_if.rd_data,   32'h0);
        chk("rst_done",     bus_if.done,      1'b0);
        chk("rst_err",      bus_if.err,       1'b0);
        chk("rst_ready",    bus_if.cmd_ready, 1'b0);
        chk("hprot",        bus_if.hprot,     4'b0001);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus_if.cmd_ready, 1'b1);
        @(posedge clk);
        #1;

        // Read INCR4 at 0x200, zero wait states
        clear_scripts();
        rdata_s[2] = 32'h11; rdata_s[3] = 32'h22; rdata_s[4] = 32'h33; rdata_s[5] = 32'h44;
        issue(1'b0, 32'h200, 3'b010, 1'b1, '0, 7);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("rd4_haddr%0d", k), tr_haddr[k], 32'h200 + 32'(4 * (k - 1)));
            chk($sformatf("rd4_htrans%0d", k), tr_htrans[k], (k == 1) ? 2'b10 : 2'b11);
        end
        chk("rd4_hburst", tr_hburst[1], 3'b011);
        chk("rd4_hwrite", tr_hwrite[1], 1'b0);
        chk("rd4_last_idle", tr_htrans[5], 2'b00);
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("rd4_rv%0d", k), tr_rv[k], (k >= 3 && k <= 6));
            chk($sformatf("rd4_done%0d", k), tr_done[k], (k == 6));
        end
        for (int k = 3; k <= 6; k++)
            chk($sformatf("rd4_data%0d", k), tr_rd[k], 32'h11 * 32'(k - 2));
        chk("rd4_err", tr_err[6], 1'b0);

        // Write INCR4 at 0x200 with two wait states during beat 2 address phase
        clear_scripts();
        rdy_s[3] = 1'b0; rdy_s[4] = 1'b0;
        issue(1'b1, 32'h200, 3'b010, 1'b1,
              {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 9);
        chk("wr4_hwrite", tr_hwrite[1], 1'b1);
        chk("wr4_haddr2", tr_haddr[2], 32'h204);
        chk("wr4_hwdata2", tr_hwdata[2], 32'h11111111);
        for (int k = 3; k <= 5; k++) begin
            chk($sformatf("wr4_wait_haddr%0d", k), tr_haddr[k], 32'h208);
            chk($sformatf("wr4_wait_htrans%0d", k), tr_htrans[k], 2'b11);
            chk($sformatf("wr4_wait_hwdata%0d", k), tr_hwdata[k], 32'h22222222);
        end
        chk("wr4_haddr6", tr_haddr[6], 32'h20C);
        chk("wr4_hwdata6", tr_hwdata[6], 32'h33333333);
        chk("wr4_htrans7", tr_htrans[7], 2'b00);
        chk("wr4_hwdata7", tr_hwdata[7], 32'h44444444);
        for (int k = 1; k <= 9; k++)
            chk($sformatf("wr4_done%0d", k), tr_done[k], (k == 8));
        chk("wr4_err", tr_err[8], 1'b0);

        // Read INCR4 with ERROR on beat 1
        clear_scripts();
        rdata_s[2] = 32'h11;
        resp_s[3] = 2'b01; rdy_s[3] = 1'b0;
        resp_s[4] = 2'b01; rdy_s[4] = 1'b1;
        issue(1'b0, 32'h200, 3'b010, 1'b1, '0, 6);
        chk("err_htrans3", tr_htrans[3], 2'b00);
        chk("err_htrans4", tr_htrans[4], 2'b00);
        cnt = 0;
        for (int k = 1; k <= 6; k++)
            if (tr_htrans[k] == 2'b11 && tr_haddr[k] == 32'h208) cnt++;
        chk("err_no_seq_208", cnt, 0);
        cnt = 0;
        for (int k = 1; k <= 6; k++)
            if (tr_rv[k]) cnt++;
        chk("err_rv_count", cnt, 1);
        chk("err_rd_data3", tr_rd[3], 32'h11);
        for (int k = 1; k <= 6; k++)
            chk($sformatf("err_done%0d", k), tr_done[k], (k == 5));
        chk("err_err5", tr_err[5], 1'b1);
        chk("err_hold6", tr_err[6], 1'b1);
        chk("err_ready5", tr_ready[5], 1'b1);

        // Single-command vector table (legal and rejected)
        for (int i = 0; i < 9; i++) begin
            clear_scripts();
            rdata_s[2] = vecs[i].rd0;
            issue(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].burst, {96'h0, vecs[i].wd0}, 4);
            if (vecs[i].exp_err) begin
                for (int k = 1; k <= 4; k++)
                    chk({vecs[i].nm, $sformatf("_htrans%0d", k)}, tr_htrans[k], 2'b00);
                chk({vecs[i].nm, "_done1"}, tr_done[1], 1'b1);
                chk({vecs[i].nm, "_err1"}, tr_err[1], 1'b1);
                chk({vecs[i].nm, "_done2"}, tr_done[2], 1'b0);
                chk({vecs[i].nm, "_ready1"}, tr_ready[1], 1'b1);
            end else begin
                chk({vecs[i].nm, "_htrans1"}, tr_htrans[1], 2'b10);
                chk({vecs[i].nm, "_haddr1"}, tr_haddr[1], vecs[i].addr);
                chk({vecs[i].nm, "_hwrite1"}, tr_hwrite[1], vecs[i].wr);
                chk({vecs[i].nm, "_hsize1"}, tr_hsize[1], vecs[i].size);
                chk({vecs[i].nm, "_hburst1"}, tr_hburst[1], 3'b000);
                chk({vecs[i].nm, "_ready1"}, tr_ready[1], 1'b0);
                chk({vecs[i].nm, "_htrans2"}, tr_htrans[2], 2'b00);
                if (vecs[i].wr)
                    chk({vecs[i].nm, "_hwdata2"}, tr_hwdata[2], vecs[i].wd0);
                else begin
                    chk({vecs[i].nm, "_rv3"}, tr_rv[3], 1'b1);
                    chk({vecs[i].nm, "_rd3"}, tr_rd[3], vecs[i].rd0);
                end
                chk({vecs[i].nm, "_done2"}, tr_done[2], 1'b0);
                chk({vecs[i].nm, "_done3"}, tr_done[3], 1'b1);
                chk({vecs[i].nm, "_err3"}, tr_err[3], 1'b0);
                chk({vecs[i].nm, "_ready3"}, tr_ready[3], 1'b1);
            end
        end

        // Reset asserted while beat 2 address is on the bus
        clear_scripts();
        rst_s[3] = 1'b1; rst_s[4] = 1'b1;
        issue(1'b1, 32'h200, 3'b010, 1'b1, {4{32'hA5A5A5A5}}, 8);
        chk("rstmid_htrans3", tr_htrans[3], 2'b11);
        chk("rstmid_htrans4", tr_htrans[4], 2'b00);
        chk("rstmid_haddr4", tr_haddr[4], 32'h0);
        chk("rstmid_ready4", tr_ready[4], 1'b0);
        chk("rstmid_ready5", tr_ready[5], 1'b1);
        cnt = 0;
        for (int k = 1; k <= 8; k++)
            if (tr_done[k]) cnt++;
        chk("rstmid_no_done", cnt, 0);
        for (int k = 5; k <= 8; k++)
            chk($sformatf("rstmid_idle%0d", k), tr_htrans[k], 2'b00);

        // RETRY on beat 0 of a read INCR4
        clear_scripts();
        resp_s[2] = 2'b10; rdy_s[2] = 1'b0;
        resp_s[3] = 2'b10; rdy_s[3] = 1'b1;
        rdata_s[5] = 32'hA1; rdata_s[6] = 32'hA2; rdata_s[7] = 32'hA3; rdata_s[8] = 32'hA4;
        issue(1'b0, 32'h200, 3'b010, 1'b1, '0, 10);
        chk("retry_htrans2", tr_htrans[2], 2'b00);
        chk("retry_htrans3", tr_htrans[3], 2'b00);
`ifdef AHB_MST_RETRY_EN
        chk("retry_reissue_htrans", tr_htrans[4], 2'b10);
        chk("retry_reissue_haddr", tr_haddr[4], 32'h200);
        for (int k = 5; k <= 7; k++) begin
            chk($sformatf("retry_htrans%0d", k), tr_htrans[k], 2'b11);
            chk($sformatf("retry_haddr%0d", k), tr_haddr[k], 32'h200 + 32'(4 * (k - 4)));
        end
        chk("retry_htrans8", tr_htrans[8], 2'b00);
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("retry_rv%0d", k), tr_rv[k], (k >= 6 && k <= 9));
            chk($sformatf("retry_done%0d", k), tr_done[k], (k == 9));
        end
        for (int k = 6; k <= 9; k++)
            chk($sformatf("retry_rd%0d", k), tr_rd[k], 32'hA1 + 32'(k - 6));
        chk("retry_err", tr_err[9], 1'b0);
`else
        for (int k = 1; k <= 10; k++)
            chk($sformatf("retry_as_err_done%0d", k), tr_done[k], (k == 4));
        chk("retry_as_err_err", tr_err[4], 1'b1);
        cnt = 0;
        for (int k = 2; k <= 10; k++)
            if (tr_htrans[k] != 2'b00 || tr_rv[k]) cnt++;
        chk("retry_as_err_quiet", cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
